// File: rtl/scratchpad_arbiter.sv
// scratchpad_arbiter: round-robin share of a 1-port scratchpad RAM with a zeroize sweep engine
module scratchpad_arbiter #(
  parameter int                NUM_REQ     = 2,
  parameter int                DATA_W      = 64,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [31:0]       DEPTH_BYTES = 32'h100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_mask,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_W-1:0]     rsp_rdata,
  output logic [NUM_REQ-1:0]            rsp_error,
  input  logic                          zeroize_start,
  output logic                          zeroize_busy,
  output logic                          zeroize_done,
  output logic                          ram_req,
  output logic                          ram_write,
  output logic [$clog2(DEPTH_BYTES/8)-1:0] ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [DATA_W-1:0]             ram_wmask,
  input  logic [DATA_W-1:0]             ram_rdata
);
  localparam int DEPTH_W = int'(DEPTH_BYTES / 8);
  localparam int AW = $clog2(DEPTH_W);
  localparam int MW = DATA_W / 8;
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(DEPTH_W);
  typedef enum logic {IDLE, ZERO} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt_idx;
  logic done_q, done_d, found, sel_wr, sel_err;
  logic [NUM_REQ-1:0] elig, gnt;
  logic [NUM_REQ-1:0] pend_q, pend_d, pend_err_q, pend_err_d, pend_zero_q, pend_zero_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [NUM_REQ*DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] sel_addr, sel_word;
  logic [DATA_W-1:0] sel_wdata;
  logic [MW-1:0] sel_mask;
  int idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      done_q      <= 1'b0;
      pend_q      <= '0;
      pend_err_q  <= '0;
      pend_zero_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
      pend_zero_q <= pend_zero_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (zeroize_start ? ZERO : IDLE)
                              : (cnt_q == AW'(DEPTH_W - 1) ? IDLE : ZERO);
    done_d  = state_q == ZERO && cnt_q == AW'(DEPTH_W - 1);
    cnt_d   = state_q == ZERO && !done_d ? cnt_q + 1'b1 : '0;
  end
  // A requester with a pending or unconsumed response is skipped until its slot drains.
  assign elig = req_valid & ~pend_q & ~rsp_valid_q;
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(ptr_q) + j) % NUM_REQ;
      if (!found && elig[idx] && state_q == IDLE && !rst) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end
  assign ptr_d     = found ? PW'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_mask  = req_mask[int'(gnt_idx)*MW +: MW];
  assign sel_wr    = req_write[gnt_idx];
  assign sel_word  = (sel_addr - BASE_ADDR) >> 3;
  assign sel_err   = sel_addr < BASE_ADDR || sel_word >= DEPTH_WORDS;
  always_comb begin
    ram_req   = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (state_q == ZERO) begin
      ram_req   = 1'b1;
      ram_write = 1'b1;
      ram_addr  = cnt_q;
      ram_wmask = '1;
    end else if (found && !sel_err) begin
      ram_req   = 1'b1;
      ram_write = sel_wr;
      ram_addr  = sel_word[AW-1:0];
      ram_wdata = sel_wdata;
      for (int b = 0; b < MW; b++) ram_wmask[b*8 +: 8] = {8{sel_mask[b]}};
    end
  end
  // Writes and errors complete with zero data; reads take the RAM output one cycle after accept.
  always_comb begin
    pend_d      = gnt;
    pend_err_d  = gnt & {NUM_REQ{sel_err}};
    pend_zero_d = gnt & {NUM_REQ{sel_err | sel_wr}};
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rdata_d     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = pend_q[i] | (rsp_valid_q[i] & ~rsp_ready[i]);
      rsp_err_d[i]   = pend_q[i] ? pend_err_q[i] : rsp_err_q[i] & rsp_valid_d[i];
      rdata_d[i*DATA_W +: DATA_W] = pend_q[i] ? (pend_zero_q[i] ? '0 : ram_rdata)
                                  : (rsp_valid_d[i] ? rdata_q[i*DATA_W +: DATA_W] : '0);
    end
  end
  assign req_ready    = gnt;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_err_q;
  assign rsp_rdata    = rdata_q;
  assign zeroize_busy = state_q == ZERO;
  assign zeroize_done = done_q;
endmodule
